// File: rtl/i2c_pkg.sv
// Shared command codes and FSM state encodings for the I2C bit-level master.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_XFER  = 2'd3;

endpackage

// File: rtl/i2c_phase_timer.sv
// Bit-phase divider: 2^DW clk cycles per phase, 4 phases per bit.
module i2c_phase_timer #(
  parameter int unsigned DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       phase_tick,
  output logic [1:0] phase
);

  logic [DW-1:0] cnt;

  // phase_tick marks the last cycle of the current phase
  assign phase_tick = (cnt == '1);

  // Divider and phase index, restarted from zero on clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      cnt <= cnt + DW'(1);
      if (phase_tick) phase <= phase + 2'd1;
    end
  end

endmodule

// File: rtl/i2c_cmd_phy.sv
// Bit-level I2C master executing one START/STOP/WRITE/READ command at a time.
module i2c_cmd_phy #(
  parameter int unsigned DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  input  logic [1:0] cmd,
  input  logic       stb,
  output logic [7:0] data_out,
  output logic       ack_out,
  output logic       ready
);

  import i2c_pkg::*;

  logic [1:0] state;
  logic [1:0] cmd_q;
  logic [7:0] tx_q;
  logic       ack_q;
  logic [3:0] bit_idx;
  logic [7:0] rx_sh;
  logic       ack_smp;
  logic       phase_tick;
  logic [1:0] phase;
  logic       accept;

  // Target of the upcoming phase (the one whose first cycle follows this edge)
  logic       load;
  logic       done;
  logic [1:0] t_state;
  logic [1:0] t_cmd;
  logic [7:0] t_tx;
  logic       t_ack;
  logic [1:0] t_phase;
  logic [3:0] t_bit;
  logic [2:0] t_sel;
  logic       t_bitv;
  logic       nxt_scl;
  logic       nxt_sda;

  assign ready  = (state == ST_IDLE);
  assign accept = stb && ready;

  i2c_phase_timer #(.DW(DW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .phase_tick (phase_tick),
    .phase      (phase)
  );

  // Pins are registered, so the next phase is resolved one edge early:
  // on acceptance (entering Q0) or on the tick ending the current phase.
  always_comb begin
    load    = 1'b0;
    done    = 1'b0;
    t_state = state;
    t_cmd   = cmd_q;
    t_tx    = tx_q;
    t_ack   = ack_q;
    t_phase = phase;
    t_bit   = bit_idx;
    if (accept) begin
      load    = 1'b1;
      t_cmd   = cmd;
      t_tx    = data_in;
      t_ack   = ack_in;
      t_phase = 2'd0;
      t_bit   = 4'd8;
      case (cmd)
        CMD_START: t_state = ST_START;
        CMD_STOP:  t_state = ST_STOP;
        default:   t_state = ST_XFER;
      endcase
    end else if (state != ST_IDLE && phase_tick) begin
      if (phase != 2'd3) begin
        load    = 1'b1;
        t_phase = phase + 2'd1;
      end else if (state == ST_XFER && bit_idx != 4'd0) begin
        load    = 1'b1;
        t_phase = 2'd0;
        t_bit   = bit_idx - 4'd1;
      end else begin
        done = 1'b1;
      end
    end
  end

  // Logical SDA value of the target bit (1 = released)
  always_comb begin
    t_sel = 3'(t_bit - 4'd1);
    if (t_bit == 4'd0) t_bitv = (t_cmd == CMD_READ) ? t_ack : 1'b1;
    else               t_bitv = (t_cmd == CMD_WRITE) ? t_tx[t_sel] : 1'b1;
  end

  // Pin levels for the first cycle of the target phase; otherwise hold
  always_comb begin
    nxt_scl = scl_oe;
    nxt_sda = sda_oe;
    if (load) begin
      case (t_state)
        ST_START: begin
          case (t_phase)
            2'd0:    nxt_sda = 1'b0;
            2'd1:    nxt_scl = 1'b0;
            2'd2:    nxt_sda = 1'b1;
            default: nxt_scl = 1'b1;
          endcase
        end
        ST_STOP: begin
          case (t_phase)
            2'd0: begin
              nxt_scl = 1'b1;
              nxt_sda = 1'b1;
            end
            2'd1:    nxt_scl = 1'b0;
            2'd2:    nxt_sda = 1'b0;
            default: ;
          endcase
        end
        ST_XFER: begin
          case (t_phase)
            2'd0: begin
              nxt_scl = 1'b1;
              nxt_sda = ~t_bitv;
            end
            2'd1, 2'd2: nxt_scl = 1'b0;
            default:    nxt_scl = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // FSM, command latches, sampling and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      cmd_q    <= '0;
      tx_q     <= '0;
      ack_q    <= 1'b0;
      bit_idx  <= '0;
      rx_sh    <= '0;
      ack_smp  <= 1'b0;
      data_out <= '0;
      ack_out  <= 1'b0;
    end else begin
      scl_oe <= nxt_scl;
      sda_oe <= nxt_sda;
      if (accept) begin
        state   <= t_state;
        cmd_q   <= cmd;
        tx_q    <= data_in;
        ack_q   <= ack_in;
        bit_idx <= 4'd8;
      end else if (load) begin
        bit_idx <= t_bit;
      end
      if (state == ST_XFER && phase_tick && phase == 2'd2) begin
        if (bit_idx == 4'd0) ack_smp <= sda_i;
        else                 rx_sh   <= {rx_sh[6:0], sda_i};
      end
      if (done) begin
        state <= ST_IDLE;
        if (cmd_q == CMD_WRITE) ack_out  <= ack_smp;
        if (cmd_q == CMD_READ)  data_out <= rx_sh;
      end
    end
  end

endmodule
